// File: rtl/mem256_arbiter_if.sv
// Request, response and RAM-side signals of the two-port Mem256x16 arbiter.
// slave = the arbiter; master = the requesters and the RAM.
interface mem256_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              a_req, b_req;
  logic              a_we, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt, b_gnt;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              a_rvalid, b_rvalid;
  logic              mem_rd_en, mem_wr_en;
  logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  logic              mem_valid_out;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
    input  mem_data_out, mem_valid_out,
    output a_gnt, b_gnt, a_rdata, b_rdata, a_rvalid, b_rvalid,
    output mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_data_in
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
    output mem_data_out, mem_valid_out,
    input  a_gnt, b_gnt, a_rdata, b_rdata, a_rvalid, b_rvalid,
    input  mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_data_in
  );
endinterface

// File: rtl/mem256_arbiter.sv
// Two-port arbiter/sequencer for a 1R1W registered-read block RAM.
// Define MEMARB_FIXED_PRIO_EN to make port A win every same-type conflict.
module mem256_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mem256_arbiter_if.slave bus
);
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} owner_e;

  logic   prio, prio_nxt;
  owner_e rd_owner, owner_nxt;
  logic   gnt_a, gnt_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio     <= 1'b0;
      rd_owner <= OWN_NONE;
    end else begin
      prio     <= prio_nxt;
      rd_owner <= owner_nxt;
    end
  end

  always_comb begin
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    prio_nxt  = prio;
    owner_nxt = OWN_NONE;
    if (rst_n) begin
      if (bus.a_req && bus.b_req) begin
        if (bus.a_we != bus.b_we) begin
          // Same-address read/write: only the write goes, the read retries.
          if (bus.a_addr == bus.b_addr) begin
            gnt_a = bus.a_we;
            gnt_b = bus.b_we;
          end else begin
            gnt_a = 1'b1;
            gnt_b = 1'b1;
          end
        end else begin
          gnt_a = ~prio;
          gnt_b = prio;
`ifdef MEMARB_FIXED_PRIO_EN
          prio_nxt = 1'b0;
`else
          prio_nxt = gnt_a;
`endif
        end
      end else begin
        gnt_a = bus.a_req;
        gnt_b = bus.b_req;
      end
      if (gnt_a && !bus.a_we)      owner_nxt = OWN_A;
      else if (gnt_b && !bus.b_we) owner_nxt = OWN_B;
    end
  end

  logic              rd_a, rd_b, wr_a, wr_b;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    rd_a    = gnt_a && !bus.a_we;
    rd_b    = gnt_b && !bus.b_we;
    wr_a    = gnt_a && bus.a_we;
    wr_b    = gnt_b && bus.b_we;
    rd_addr = rd_a ? bus.a_addr : (rd_b ? bus.b_addr : '0);
    wr_addr = wr_a ? bus.a_addr : (wr_b ? bus.b_addr : '0);
    wr_data = wr_a ? bus.a_wdata : (wr_b ? bus.b_wdata : '0);

    bus.a_gnt       = gnt_a;
    bus.b_gnt       = gnt_b;
    bus.mem_rd_en   = rd_a || rd_b;
    bus.mem_wr_en   = wr_a || wr_b;
    bus.mem_rd_addr = rd_addr;
    bus.mem_wr_addr = wr_addr;
    bus.mem_data_in = wr_data;

    // Gated by rst_n too, so a read returning while reset is low never leaks out.
    bus.a_rvalid = rst_n && bus.mem_valid_out && (rd_owner == OWN_A);
    bus.b_rvalid = rst_n && bus.mem_valid_out && (rd_owner == OWN_B);
    bus.a_rdata  = bus.a_rvalid ? bus.mem_data_out : '0;
    bus.b_rdata  = bus.b_rvalid ? bus.mem_data_out : '0;
  end
endmodule

// File: tb/tb_mem256_arbiter.sv
// Random + directed bench for mem256_arbiter against a behavioural model with a RAM stub.
module tb_mem256_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem256_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem256_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  function automatic logic [15:0] finit(input int a);
    if (a == 16) return 16'h1234;
    return 16'((a * 257) ^ 16'h5A3C);
  endfunction

  // RAM stub: registered read, valid one cycle after rd_en
  logic [DW-1:0] ram [256];
  logic [255:0]  ram_wr = '0;
  logic [DW-1:0] ram_q = '0;
  logic          ram_v = 1'b0;
  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      ram[bus.mem_wr_addr]    <= bus.mem_data_in;
      ram_wr[bus.mem_wr_addr] <= 1'b1;
    end
    ram_v <= bus.mem_rd_en;
    if (bus.mem_rd_en)
      ram_q <= ram_wr[bus.mem_rd_addr] ? ram[bus.mem_rd_addr] : finit(int'(bus.mem_rd_addr));
  end
  assign bus.mem_data_out  = ram_q;
  assign bus.mem_valid_out = ram_v;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: memory contents, favoured port, pending read (0 none, 1 A, 2 B)
  logic [DW-1:0] mdl [256];
  int            m_prio = 0;
  int            m_pend = 0;
  logic [DW-1:0] m_pend_data = '0;
  logic          m_ga, m_gb;

  logic          s_a_gnt, s_b_gnt, s_a_rv, s_b_rv, s_rd_en, s_wr_en;
  logic [DW-1:0] s_a_rd, s_b_rd;

  task automatic step(input logic ar, input logic aw, input logic [7:0] aad, input logic [15:0] awd,
                      input logic br, input logic bw, input logic [7:0] bad, input logic [15:0] bwd);
    logic ea, eb, ra, rb, wa, wb, e_av, e_bv;
    logic [7:0] e_ra, e_wa;
    logic [15:0] e_wd;
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = aad; bus.a_wdata = awd;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = bad; bus.b_wdata = bwd;
    @(negedge clk);
    ea = 1'b0; eb = 1'b0;
    if (rst_n) begin
      if (ar && br && aw == bw) begin
        ea = (m_prio == 0);
        eb = !ea;
      end else if (ar && br && aad == bad) begin
        ea = aw;
        eb = bw;
      end else begin
        ea = ar;
        eb = br;
      end
    end
    ra = ea && !aw; rb = eb && !bw; wa = ea && aw; wb = eb && bw;
    e_ra = ra ? aad : (rb ? bad : 8'h00);
    e_wa = wa ? aad : (wb ? bad : 8'h00);
    e_wd = wa ? awd : (wb ? bwd : 16'h0000);
    e_av = rst_n && m_pend == 1;
    e_bv = rst_n && m_pend == 2;
    chk("a_gnt", bus.a_gnt, ea);
    chk("b_gnt", bus.b_gnt, eb);
    chk("mem_rd_en", bus.mem_rd_en, ra || rb);
    chk("mem_wr_en", bus.mem_wr_en, wa || wb);
    chk("mem_rd_addr", bus.mem_rd_addr, e_ra);
    chk("mem_wr_addr", bus.mem_wr_addr, e_wa);
    chk("mem_data_in", bus.mem_data_in, e_wd);
    chk("a_rvalid", bus.a_rvalid, e_av);
    chk("b_rvalid", bus.b_rvalid, e_bv);
    chk("a_rdata", bus.a_rdata, e_av ? m_pend_data : 16'h0);
    chk("b_rdata", bus.b_rdata, e_bv ? m_pend_data : 16'h0);
    s_a_gnt = bus.a_gnt; s_b_gnt = bus.b_gnt; s_a_rv = bus.a_rvalid; s_b_rv = bus.b_rvalid;
    s_a_rd = bus.a_rdata; s_b_rd = bus.b_rdata; s_rd_en = bus.mem_rd_en; s_wr_en = bus.mem_wr_en;
    m_ga = ea; m_gb = eb;
    if (!rst_n) begin
      m_prio = 0;
      m_pend = 0;
    end else begin
      m_pend = ra ? 1 : (rb ? 2 : 0);
      if (ra) m_pend_data = mdl[aad];
      if (rb) m_pend_data = mdl[bad];
      if (wa) mdl[aad] = awd;
      if (wb) mdl[bad] = bwd;
`ifndef MEMARB_FIXED_PRIO_EN
      if (ar && br && aw == bw) m_prio = ea ? 1 : 0;
`endif
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
  endtask

  logic [3:0] pa, pb;
  logic       a_r, a_w, b_r, b_w, a_hold, b_hold;
  logic [7:0] a_ad, b_ad;
  logic [15:0] a_wd, b_wd;

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = finit(i);
    rst_n = 1'b0;
    idle();
    step(1, 1, 8'h20, 16'hAAAA, 1, 0, 8'h21, 16'h0);
    chk("reset_a_gnt", s_a_gnt, 1'b0);
    chk("reset_wr_en", s_wr_en, 1'b0);
    idle();
    rst_n = 1'b1;

    step(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0);
    chk("t1_a_gnt", s_a_gnt, 1'b1);
    idle();
    chk("t1_a_rvalid", s_a_rv, 1'b1);
    chk("t1_a_rdata", s_a_rd, 16'h1234);
    chk("t1_b_rvalid", s_b_rv, 1'b0);

    step(1, 0, 8'h05, 16'h0, 1, 1, 8'h22, 16'hBEEF);
    chk("t2_gnt_both", {s_a_gnt, s_b_gnt, s_rd_en, s_wr_en}, 4'b1111);
    step(0, 0, 8'h00, 16'h0, 1, 0, 8'h22, 16'h0);
    chk("t2_a_rdata", s_a_rd, 16'h5F39);
    idle();
    chk("t2_b_rdata", s_b_rd, 16'hBEEF);

    pa = '0; pb = '0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 8'h01, 16'h0, 1, 0, 8'h02, 16'h0);
      pa = {pa[2:0], s_a_gnt};
      pb = {pb[2:0], s_b_gnt};
    end
`ifdef MEMARB_FIXED_PRIO_EN
    chk("t3_a_pattern", pa, 4'b1111);
    chk("t3_b_pattern", pb, 4'b0000);
`else
    chk("t3_a_pattern", pa, 4'b1010);
    chk("t3_b_pattern", pb, 4'b0101);
`endif
    idle();

    step(1, 0, 8'h40, 16'h0, 1, 1, 8'h40, 16'h5A5A);
    chk("t4_stall", {s_a_gnt, s_b_gnt}, 2'b01);
    step(1, 0, 8'h40, 16'h0, 0, 0, 8'h00, 16'h0);
    chk("t4_retry_gnt", s_a_gnt, 1'b1);
    idle();
    chk("t4_a_rdata", s_a_rd, 16'h5A5A);

    step(1, 0, 8'h11, 16'h0, 0, 0, 8'h00, 16'h0);
    rst_n = 1'b0;
    idle();
    chk("t5_rvalid_n1", s_a_rv, 1'b0);
    step(1, 0, 8'h12, 16'h0, 1, 1, 8'h13, 16'h1);
    chk("t5_rvalid_n2", s_a_rv, 1'b0);
    chk("t5_en_in_reset", {s_rd_en, s_wr_en, s_a_gnt, s_b_gnt}, 4'b0000);
    rst_n = 1'b1;
    step(1, 0, 8'h03, 16'h0, 1, 0, 8'h04, 16'h0);
    chk("t5_prio_after_rst", {s_a_gnt, s_b_gnt}, 2'b10);
    step(0, 0, 8'h00, 16'h0, 1, 0, 8'h04, 16'h0);
    chk("t5_b_gnt", s_b_gnt, 1'b1);
    idle();

    step(1, 1, 8'h30, 16'h1111, 1, 1, 8'h31, 16'h2222);
`ifdef MEMARB_FIXED_PRIO_EN
    chk("t6_first_wr", {s_a_gnt, s_b_gnt}, 2'b10);
    chk("t6_wr_en0", s_wr_en, 1'b1);
    step(0, 0, 8'h00, 16'h0, 1, 1, 8'h31, 16'h2222);
    chk("t6_second_wr", s_b_gnt, 1'b1);
`else
    chk("t6_first_wr", {s_a_gnt, s_b_gnt}, 2'b01);
    chk("t6_wr_en0", s_wr_en, 1'b1);
    step(1, 1, 8'h30, 16'h1111, 0, 0, 8'h00, 16'h0);
    chk("t6_second_wr", s_a_gnt, 1'b1);
`endif
    chk("t6_wr_en1", s_wr_en, 1'b1);
    step(1, 0, 8'h31, 16'h0, 0, 0, 8'h00, 16'h0);
    idle();
    chk("t6_readback", s_a_rd, 16'h2222);

    a_hold = 1'b0; b_hold = 1'b0;
    a_r = 0; a_w = 0; a_ad = 0; a_wd = 0; b_r = 0; b_w = 0; b_ad = 0; b_wd = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (!a_hold) begin
        a_r = ($urandom_range(0, 3) != 0); a_w = 1'($urandom);
        a_ad = 8'($urandom_range(0, 7)); a_wd = 16'($urandom);
      end
      if (!b_hold) begin
        b_r = ($urandom_range(0, 3) != 0); b_w = 1'($urandom);
        b_ad = 8'($urandom_range(0, 7)); b_wd = 16'($urandom);
      end
      step(a_r, a_w, a_ad, a_wd, b_r, b_w, b_ad, b_wd);
      a_hold = a_r && !m_ga;
      b_hold = b_r && !m_gb;
    end
    rst_n = 1'b1;
    idle();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
